// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one full-subtractor cell
// and a registered borrow, with valid/ready handshakes on both sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_shift;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign r_shift = {d_bit, r_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        r_d   = r_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = r_shift;
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed WIDTH=4 cases plus randomized WIDTH=8 ops against
// an arithmetic reference model (plain integer subtraction).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic       iv4, ir4, ov4, or4, bin4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       iv8, ir8, ov8, or8, bin8, bout8;
  logic [7:0] a8, b8, diff8;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bin4),
    .out_valid(ov4), .out_ready(or4), .diff(diff4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(diff8), .bout(bout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer subtraction, reduced modulo 2^w; borrow when the result is negative.
  function automatic void model(input int w, input int av, input int bv, input int bi,
                                output int d, output int bo);
    int r;
    r  = av - bv - bi;
    d  = r & ((1 << w) - 1);
    bo = (r < 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] f_ov(input bit w8);   return w8 ? 32'(ov8)   : 32'(ov4);   endfunction
  function automatic logic [31:0] f_ir(input bit w8);   return w8 ? 32'(ir8)   : 32'(ir4);   endfunction
  function automatic logic [31:0] f_diff(input bit w8); return w8 ? 32'(diff8) : 32'(diff4); endfunction
  function automatic logic [31:0] f_bout(input bit w8); return w8 ? 32'(bout8) : 32'(bout4); endfunction

  task automatic set_in(input bit w8, input bit v, input int av, input int bv, input int bi);
    if (w8) begin iv8 = v; a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(bi); end
    else    begin iv4 = v; a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi); end
  endtask

  task automatic set_or(input bit w8, input bit v);
    if (w8) or8 = v; else or4 = v;
  endtask

  // Entered #1 after the accepting edge. Waits for the result, holds it for `stall`
  // cycles, optionally presents a new op during DONE (left asserted), then handshakes.
  task automatic finish_op(input bit w8, input int av, input int bv, input int bi,
                           input int stall, input bit poke, input int pa, input int pb);
    int w, cyc, ed, eb;
    w = w8 ? 8 : 4;
    model(w, av, bv, bi, ed, eb);
    check("accept_in_ready", f_ir(w8), 0);
    @(negedge clk);
    set_in(w8, 1'b0, int'($urandom), int'($urandom), int'($urandom_range(0, 1)));
    cyc = 0;
    while (f_ov(w8) !== 32'd1 && cyc < 40) begin
      @(posedge clk); cyc++; #1;
    end
    check("latency", cyc, w);
    check("diff", f_diff(w8), ed);
    check("bout", f_bout(w8), eb);
    if (poke) begin
      @(negedge clk);
      set_in(w8, 1'b1, pa, pb, 0);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_out_valid", f_ov(w8), 1);
      check("stall_in_ready", f_ir(w8), 0);
      check("stall_diff", f_diff(w8), ed);
      check("stall_bout", f_bout(w8), eb);
    end
    @(negedge clk);
    set_or(w8, 1'b1);
    @(posedge clk); #1;
    check("hs_out_valid", f_ov(w8), 0);
    check("hs_in_ready", f_ir(w8), 1);
    check("hold_diff", f_diff(w8), ed);
    check("hold_bout", f_bout(w8), eb);
    @(negedge clk);
    set_or(w8, 1'b0);
  endtask

  task automatic do_op(input bit w8, input int av, input int bv, input int bi, input int stall);
    set_in(w8, 1'b1, av, bv, bi);
    @(posedge clk); #1;
    finish_op(w8, av, bv, bi, stall, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 0, 0, 0); set_in(1, 1'b0, 0, 0, 0);
    or4 = 1'b0; or8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir4), 1);
    check("rst_out_valid", 32'(ov4), 0);
    check("rst_diff", 32'(diff4), 0);
    check("rst_bout", 32'(bout4), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic and boundary cases on the 4-bit instance.
    do_op(0, 9, 3, 0, 0);
    @(negedge clk);
    do_op(0, 3, 9, 0, 0);
    @(negedge clk);
    do_op(0, 0, 0, 1, 0);
    @(negedge clk);
    do_op(0, 15, 15, 1, 0);
    @(negedge clk);
    do_op(0, 15, 0, 0, 1);
    @(negedge clk);

    // Backpressure with a new op offered during DONE; it must wait for the handshake.
    set_in(0, 1'b1, 7, 2, 0);
    @(posedge clk); #1;
    finish_op(0, 7, 2, 0, 3, 1'b1, 13, 4);
    // finish_op left in_valid high with 13-4-0; the next edge accepts it.
    @(posedge clk); #1;
    finish_op(0, 13, 4, 0, 0, 1'b0, 0, 0);
    @(negedge clk);

    // Reset mid-RUN, two cycles after accepting 12-5-0.
    set_in(0, 1'b1, 12, 5, 0);
    @(posedge clk); #1;
    @(negedge clk);
    set_in(0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 32'(ov4), 0);
    check("midrun_rst_diff", 32'(diff4), 0);
    check("midrun_rst_bout", 32'(bout4), 0);
    check("midrun_rst_in_ready", 32'(ir4), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(0, 12, 5, 0, 0);
    @(negedge clk);

    // 8-bit directed then randomized, including back-to-back ops.
    do_op(1, 200, 55, 0, 0);
    @(negedge clk);
    do_op(1, 0, 0, 1, 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      do_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
